layer_mixer: RTL

Final per-pixel compositing stage directly downstream of the tilemap, sprite and character layers. It selects the highest-priority opaque layer pixel, or a background colour where no layer is opaque. It then scales the result by a global brightness level driven by a frame-paced fade engine, and forces black during blanking. CPU-visible control registers use the same addr/data_in/write bus style as the other video blocks.

---
 rtl/layer_mixer.sv | 242 ++++++++++++++++++++++++
 1 files changed

// File: rtl/layer_mixer.sv
// layer_mixer: picks the highest-priority opaque layer (or background), scales it by a global brightness, blanks it; 2-clock latency.
// The vblank-paced fade engine is built only when LAYER_MIXER_FADE_EN is defined; otherwise brightness is fixed at 16.
module layer_mixer #(
  parameter int FADE_STEP_FRAMES = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       hblank,
  input  logic       vblank,
  input  logic [2:0] addr,
  input  logic [7:0] data_in,
  input  logic       write,
  output logic [7:0] control_data_out,
  input  logic [7:0] tilemap_r,
  input  logic [7:0] tilemap_g,
  input  logic [7:0] tilemap_b,
  input  logic       tilemap_a,
  input  logic [7:0] sprite_r,
  input  logic [7:0] sprite_g,
  input  logic [7:0] sprite_b,
  input  logic       sprite_a,
  input  logic [7:0] char_r,
  input  logic [7:0] char_g,
  input  logic [7:0] char_b,
  input  logic       char_a,
  output logic [7:0] out_r,
  output logic [7:0] out_g,
  output logic [7:0] out_b,
  output logic       out_hblank,
  output logic       out_vblank
);

  if (FADE_STEP_FRAMES < 1 || FADE_STEP_FRAMES > 255) begin : g_bad_step
    $error("layer_mixer: FADE_STEP_FRAMES must be in 1..255");
  end

  logic [7:0] bg_r_q, bg_r_d, bg_g_q, bg_g_d, bg_b_q, bg_b_d;
  logic       prio_q, prio_d;
  logic [2:0] en_q, en_d;
  logic [4:0] reg4_rd, bright_rd;
  logic       busy_rd;

  always_comb begin
    bg_r_d = bg_r_q;
    bg_g_d = bg_g_q;
    bg_b_d = bg_b_q;
    prio_d = prio_q;
    en_d   = en_q;
    if (write) begin
      case (addr)
        3'd0:    bg_r_d = data_in;
        3'd1:    bg_g_d = data_in;
        3'd2:    bg_b_d = data_in;
        3'd3:    prio_d = data_in[0];
        3'd7:    en_d   = data_in[2:0];
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bg_r_q <= 8'd0;
      bg_g_q <= 8'd0;
      bg_b_q <= 8'd0;
      prio_q <= 1'b0;
      en_q   <= 3'b111;
    end else begin
      bg_r_q <= bg_r_d;
      bg_g_q <= bg_g_d;
      bg_b_q <= bg_b_d;
      prio_q <= prio_d;
      en_q   <= en_d;
    end
  end

`ifdef LAYER_MIXER_FADE_EN
  typedef enum logic [1:0] {IDLE, WAIT, STEP} fade_state_e;
  localparam logic [7:0] STEP_LAST = 8'(FADE_STEP_FRAMES - 1);

  fade_state_e state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [4:0]  reg4_q, reg4_d, tgt_q, tgt_d, bright_q, bright_d;
  logic        vblank_q;
  logic        start_wr, vb_edge;

  assign start_wr = write && (addr == 3'd5) && data_in[0];
  assign vb_edge  = vblank && !vblank_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    reg4_d   = reg4_q;
    tgt_d    = tgt_q;
    bright_d = bright_q;
    if (write && addr == 3'd4) reg4_d = (data_in > 8'd16) ? 5'd16 : data_in[4:0];
    case (state_q)
      IDLE: begin
        if (start_wr) begin
          tgt_d = reg4_q;
          if (reg4_q != bright_q) begin
            cnt_d   = 8'd0;
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (start_wr) tgt_d = reg4_q;
        if (vb_edge) begin
          if (cnt_q == STEP_LAST) begin
            cnt_d   = 8'd0;
            state_d = STEP;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
      end
      STEP: begin
        // A retarget landing here takes precedence; the step waits for the next frame period.
        if (start_wr) begin
          tgt_d   = reg4_q;
          state_d = WAIT;
        end else if (bright_q == tgt_q) begin
          state_d = IDLE;
        end else begin
          bright_d = (bright_q < tgt_q) ? bright_q + 5'd1 : bright_q - 5'd1;
          state_d  = (bright_d == tgt_q) ? IDLE : WAIT;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      cnt_q    <= 8'd0;
      reg4_q   <= 5'd16;
      tgt_q    <= 5'd16;
      bright_q <= 5'd16;
      vblank_q <= 1'b1;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      reg4_q   <= reg4_d;
      tgt_q    <= tgt_d;
      bright_q <= bright_d;
      vblank_q <= vblank;
    end
  end

  function automatic logic [7:0] scale(input logic [7:0] c, input logic [4:0] lvl);
    logic [12:0] prod;
    prod = {5'd0, c} * {8'd0, lvl};
    return 8'(prod >> 4);
  endfunction

  assign reg4_rd   = reg4_q;
  assign busy_rd   = (state_q != IDLE);
  assign bright_rd = bright_q;
`else
  assign reg4_rd   = 5'd0;
  assign busy_rd   = 1'b0;
  assign bright_rd = 5'd16;
`endif

  always_comb begin
    control_data_out = 8'd0;
    case (addr)
      3'd0: control_data_out = bg_r_q;
      3'd1: control_data_out = bg_g_q;
      3'd2: control_data_out = bg_b_q;
      3'd3: control_data_out = {7'd0, prio_q};
      3'd4: control_data_out = {3'd0, reg4_rd};
      3'd5: control_data_out = {7'd0, busy_rd};
      3'd6: control_data_out = {3'd0, bright_rd};
      3'd7: control_data_out = {5'd0, en_q};
      default: ;
    endcase
  end

  logic        t_ok, s_ok, c_ok;
  logic [23:0] s1_rgb_q, s1_rgb_d;
  logic        s1_hb_q, s1_vb_q;
  logic [23:0] out_rgb_q, out_rgb_d;
  logic        out_hb_q, out_vb_q;

  assign t_ok = tilemap_a && en_q[0];
  assign s_ok = sprite_a && en_q[1];
  assign c_ok = char_a && en_q[2];

  always_comb begin
    s1_rgb_d = {bg_r_q, bg_g_q, bg_b_q};
    if (c_ok) begin
      s1_rgb_d = {char_r, char_g, char_b};
    end else if (prio_q) begin
      if (t_ok)      s1_rgb_d = {tilemap_r, tilemap_g, tilemap_b};
      else if (s_ok) s1_rgb_d = {sprite_r, sprite_g, sprite_b};
    end else begin
      if (s_ok)      s1_rgb_d = {sprite_r, sprite_g, sprite_b};
      else if (t_ok) s1_rgb_d = {tilemap_r, tilemap_g, tilemap_b};
    end
  end

  always_comb begin
    out_rgb_d = 24'd0;
    if (!s1_hb_q && !s1_vb_q) begin
`ifdef LAYER_MIXER_FADE_EN
      out_rgb_d = {scale(s1_rgb_q[23:16], bright_q),
                   scale(s1_rgb_q[15:8], bright_q),
                   scale(s1_rgb_q[7:0], bright_q)};
`else
      out_rgb_d = s1_rgb_q;
`endif
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_rgb_q  <= 24'd0;
      s1_hb_q   <= 1'b1;
      s1_vb_q   <= 1'b1;
      out_rgb_q <= 24'd0;
      out_hb_q  <= 1'b1;
      out_vb_q  <= 1'b1;
    end else begin
      s1_rgb_q  <= s1_rgb_d;
      s1_hb_q   <= hblank;
      s1_vb_q   <= vblank;
      out_rgb_q <= out_rgb_d;
      out_hb_q  <= s1_hb_q;
      out_vb_q  <= s1_vb_q;
    end
  end

  assign out_r      = out_rgb_q[23:16];
  assign out_g      = out_rgb_q[15:8];
  assign out_b      = out_rgb_q[7:0];
  assign out_hblank = out_hb_q;
  assign out_vblank = out_vb_q;

endmodule
